// File: rtl/t2c_maze_pkg.sv
// Shared encodings for the maze bot: move codes, headings, motor drive codes,
// executor FSM states and the default maze size.
package t2c_maze_pkg;

  localparam logic [2:0] MV_STOP  = 3'd0;
  localparam logic [2:0] MV_FWD   = 3'd1;
  localparam logic [2:0] MV_LEFT  = 3'd2;
  localparam logic [2:0] MV_RIGHT = 3'd3;
  localparam logic [2:0] MV_UTURN = 3'd4;

  localparam logic [1:0] HD_N = 2'd0;
  localparam logic [1:0] HD_E = 2'd1;
  localparam logic [1:0] HD_S = 2'd2;
  localparam logic [1:0] HD_W = 2'd3;

  localparam logic [1:0] MOT_STOP = 2'b00;
  localparam logic [1:0] MOT_FWD  = 2'b01;
  localparam logic [1:0] MOT_REV  = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SETTLE, ST_HALT} state_e;

  localparam int GRID_DEF = 9;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/t2c_phase_timer.sv
// Loadable down-counter that times one motor phase; expire_o is high at zero.
module t2c_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         count_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cnt_q <= '0;
    else if (load_i)                  cnt_q <= load_val_i;
    else if (count_i && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/t2c_motion_executor.sv
// Executes explorer move commands as timed motor phases and dead-reckons the
// bot's heading/position. Optional move counter is enabled by MOVE_COUNT_EN.
module t2c_motion_executor
  import t2c_maze_pkg::*;
#(
  parameter int FWD_CYCLES   = 8,
  parameter int TURN_CYCLES  = 4,
  parameter int UTURN_CYCLES = 8,
  parameter int GRID         = GRID_DEF,
  parameter int START_X      = 4,
  parameter int START_Y      = 0,
  parameter int EXIT_X       = 4,
  parameter int EXIT_Y       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] move_in,
  input  logic       move_valid,
  output logic       move_ready,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       busy,
  output logic       done_pulse,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic [1:0] heading,
  output logic       exit_reached,
  output logic       err_illegal,
  output logic [7:0] move_count
);

  localparam int CW = $clog2(max3(FWD_CYCLES, TURN_CYCLES, UTURN_CYCLES) + 1);

  state_e      state_q, state_d;
  logic [1:0]  ml_q, ml_d, mr_q, mr_d, hd_q, hd_d, phd_q, phd_d;
  logic [3:0]  x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  logic        done_q, done_d, exit_q, exit_d, err_q, err_d, pill_q, pill_d;
  logic        tmr_load, tmr_expire, can_fwd;
  logic [CW-1:0] tmr_val;
  logic [3:0]  fwd_x, fwd_y;

  t2c_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_i    (state_q == ST_RUN),
    .expire_o   (tmr_expire)
  );

  always_comb begin
    fwd_x   = x_q;
    fwd_y   = y_q;
    can_fwd = 1'b0;
    case (hd_q)
      HD_N: begin can_fwd = (y_q != 4'(GRID - 1)); fwd_y = y_q + 4'd1; end
      HD_E: begin can_fwd = (x_q != 4'(GRID - 1)); fwd_x = x_q + 4'd1; end
      HD_S: begin can_fwd = (y_q != 4'd0);          fwd_y = y_q - 4'd1; end
      default: begin can_fwd = (x_q != 4'd0);       fwd_x = x_q - 4'd1; end
    endcase
  end

  // Zero-motion commands still pass through RUN for one stopped cycle so the
  // completion lands on the second edge, same path as a one-cycle motion.
  always_comb begin
    state_d  = state_q;
    ml_d     = ml_q;
    mr_d     = mr_q;
    done_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    hd_d     = hd_q;
    exit_d   = exit_q;
    err_d    = err_q;
    px_d     = px_q;
    py_d     = py_q;
    phd_d    = phd_q;
    pill_d   = pill_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: if (move_valid) begin
        state_d  = ST_RUN;
        tmr_load = 1'b1;
        px_d     = x_q;
        py_d     = y_q;
        phd_d    = hd_q;
        pill_d   = 1'b0;
        case (move_in)
          MV_FWD: if (can_fwd) begin
            ml_d = MOT_FWD; mr_d = MOT_FWD; tmr_val = CW'(FWD_CYCLES - 1);
            px_d = fwd_x;   py_d = fwd_y;
          end else pill_d = 1'b1;
          MV_LEFT: begin
            ml_d = MOT_REV; mr_d = MOT_FWD; tmr_val = CW'(TURN_CYCLES - 1);
            phd_d = hd_q - 2'd1;
          end
          MV_RIGHT: begin
            ml_d = MOT_FWD; mr_d = MOT_REV; tmr_val = CW'(TURN_CYCLES - 1);
            phd_d = hd_q + 2'd1;
          end
          MV_UTURN: begin
            ml_d = MOT_FWD; mr_d = MOT_REV; tmr_val = CW'(UTURN_CYCLES - 1);
            phd_d = hd_q + 2'd2;
          end
          MV_STOP: ;
          default: pill_d = 1'b1;
        endcase
      end
      ST_RUN: if (tmr_expire) begin
        state_d = ST_SETTLE;
        ml_d    = MOT_STOP;
        mr_d    = MOT_STOP;
        done_d  = 1'b1;
        x_d     = px_q;
        y_d     = py_q;
        hd_d    = phd_q;
        err_d   = err_q | pill_q;
      end
      ST_SETTLE: begin
        if (x_q == 4'(EXIT_X) && y_q == 4'(EXIT_Y)) begin
          state_d = ST_HALT;
          exit_d  = 1'b1;
        end else state_d = ST_IDLE;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ml_q    <= MOT_STOP;
      mr_q    <= MOT_STOP;
      done_q  <= 1'b0;
      x_q     <= 4'(START_X);
      y_q     <= 4'(START_Y);
      hd_q    <= HD_N;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
      px_q    <= 4'(START_X);
      py_q    <= 4'(START_Y);
      phd_q   <= HD_N;
      pill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ml_q    <= ml_d;
      mr_q    <= mr_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hd_q    <= hd_d;
      exit_q  <= exit_d;
      err_q   <= err_d;
      px_q    <= px_d;
      py_q    <= py_d;
      phd_q   <= phd_d;
      pill_q  <= pill_d;
    end
  end

`ifdef MOVE_COUNT_EN
  // Only commands that actually drove the motors count as moves.
  logic       motion_q, mv_motion;
  logic [7:0] cnt_q;

  assign mv_motion = (move_in == MV_FWD && can_fwd) || move_in == MV_LEFT ||
                     move_in == MV_RIGHT || move_in == MV_UTURN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motion_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && move_valid) motion_q <= mv_motion;
      if (state_q == ST_RUN && tmr_expire && motion_q && cnt_q != 8'hFF)
        cnt_q <= cnt_q + 8'd1;
    end
  end

  assign move_count = cnt_q;
`else
  assign move_count = 8'd0;
`endif

  assign move_ready   = (state_q == ST_IDLE);
  assign busy         = (state_q == ST_RUN) || (state_q == ST_SETTLE);
  assign motor_l      = ml_q;
  assign motor_r      = mr_q;
  assign done_pulse   = done_q;
  assign pos_x        = x_q;
  assign pos_y        = y_q;
  assign heading      = hd_q;
  assign exit_reached = exit_q;
  assign err_illegal  = err_q;

endmodule

// File: tb/tb_t2c_motion_executor.sv
// Scoreboard bench: driver pushes model expectations per accepted command,
// negedge monitor checks motor activity and completion results.
module tb_t2c_motion_executor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] move_in = 3'd0;
  logic       move_valid = 1'b0;
  logic       move_ready, busy, done_pulse, exit_reached, err_illegal;
  logic [1:0] motor_l, motor_r, heading;
  logic [3:0] pos_x, pos_y;
  logic [7:0] move_count;

  t2c_motion_executor dut (
    .clk(clk), .rst_n(rst_n), .move_in(move_in), .move_valid(move_valid),
    .move_ready(move_ready), .motor_l(motor_l), .motor_r(motor_r), .busy(busy),
    .done_pulse(done_pulse), .pos_x(pos_x), .pos_y(pos_y), .heading(heading),
    .exit_reached(exit_reached), .err_illegal(err_illegal), .move_count(move_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] ml, mr;
    int n, x, y, h, cnt, acc;
    bit err;
  } exp_t;
  exp_t sb[$];

  // Reference model state: plain integers on the 9x9 grid.
  int mx, my, mh, mcnt;
  bit merr, mhalt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mx = 4; my = 0; mh = 0; mcnt = 0; merr = 0; mhalt = 0;
  endtask

  function automatic exp_t model_step(int cmd);
    exp_t e;
    int nx, ny;
    e.ml = 2'b00; e.mr = 2'b00; e.n = 0;
    case (cmd)
      1: begin
        nx = mx + ((mh == 1) ? 1 : (mh == 3) ? -1 : 0);
        ny = my + ((mh == 0) ? 1 : (mh == 2) ? -1 : 0);
        if (nx >= 0 && nx <= 8 && ny >= 0 && ny <= 8) begin
          mx = nx; my = ny; e.n = 8; e.ml = 2'b01; e.mr = 2'b01;
        end else merr = 1;
      end
      2: begin mh = (mh + 3) % 4; e.n = 4; e.ml = 2'b10; e.mr = 2'b01; end
      3: begin mh = (mh + 1) % 4; e.n = 4; e.ml = 2'b01; e.mr = 2'b10; end
      4: begin mh = (mh + 2) % 4; e.n = 8; e.ml = 2'b01; e.mr = 2'b10; end
      0: ;
      default: merr = 1;
    endcase
    if (e.n != 0 && mcnt < 255) mcnt++;
    e.x = mx; e.y = my; e.h = mh; e.err = merr;
`ifdef MOVE_COUNT_EN
    e.cnt = mcnt;
`else
    e.cnt = 0;
`endif
    mhalt = (mx == 4 && my == 8);
    return e;
  endfunction

  // Monitor: motor activity is attributed to the command at the queue head.
  int act_n = 0, bad = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      act_n = 0; bad = 0;
    end else begin
      if (motor_l != 2'b00 || motor_r != 2'b00) begin
        if (sb.size() == 0) chk("motor_when_idle", {28'd0, motor_l, motor_r}, 0);
        else begin
          act_n++;
          if (motor_l != sb[0].ml || motor_r != sb[0].mr) bad++;
        end
      end
      if (done_pulse) begin
        if (sb.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("latency", cyc - e.acc, (e.n == 0) ? 1 : e.n);
          chk("motor_cycles", act_n, e.n);
          chk("motor_pattern_bad", bad, 0);
          chk("pos_x", pos_x, e.x);
          chk("pos_y", pos_y, e.y);
          chk("heading", heading, e.h);
          chk("err_illegal", err_illegal, e.err);
          chk("move_count", move_count, e.cnt);
          chk("busy_settle", busy, 1);
          chk("ready_settle", move_ready, 0);
          chk("exit_early", exit_reached, 0);
          act_n = 0; bad = 0;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; move_valid = 1'b0; sb.delete();
    repeat (2) @(negedge clk);
    chk("rst_motor", {motor_l, motor_r}, 0);
    chk("rst_pos", {pos_x, pos_y}, {4'd4, 4'd0});
    chk("rst_heading", heading, 0);
    chk("rst_flags", {busy, done_pulse, exit_reached, err_illegal}, 0);
    chk("rst_ready", move_ready, 1);
    chk("rst_count", move_count, 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic check_halt();
    repeat (2) @(negedge clk);
    chk("exit_reached", exit_reached, 1);
    chk("halt_ready", move_ready, 0);
    chk("halt_busy", busy, 0);
    move_in = 3'd1; move_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("halt_no_accept", {move_ready, motor_l, motor_r}, 0);
    chk("halt_pos", {pos_x, pos_y}, {4'd4, 4'd8});
    move_valid = 1'b0;
  endtask

  task automatic send(int cmd);
    exp_t e;
    int t = 0;
    while (!move_ready && t < 50) begin @(negedge clk); t++; end
    if (!move_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    move_in = cmd[2:0]; move_valid = 1'b1;
    e = model_step(cmd);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    move_in = 3'($urandom);
    t = 0;
    while (sb.size() != 0 && t < 40) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
    if (mhalt) check_halt();
  endtask

  function automatic int pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 45) return 1;
    if (r < 60) return 2;
    if (r < 75) return 3;
    if (r < 85) return 4;
    if (r < 92) return 0;
    return $urandom_range(5, 7);
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    do_reset();
    send(1);
    send(3); send(4);
    do_reset();
    send(4); send(1); send(0);
    do_reset();
    send(0); send(6);
    do_reset();
    for (int i = 0; i < 8; i++) send(1);
    chk("halt_model", mhalt, 1);

    // Reset in the middle of a FORWARD phase.
    do_reset();
    move_in = 3'd1; move_valid = 1'b1;
    sb.push_back(model_step(1));
    @(posedge clk);
    #1 move_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_motor_on", {motor_l, motor_r}, 4'b0101);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrun_motor_async", {motor_l, motor_r}, 0);
    chk("midrun_pos", {pos_x, pos_y, 2'b00, heading}, {4'd4, 4'd0, 4'd0});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    send(1);

    do_reset();
    for (int i = 0; i < 250; i++) begin
      send(pick());
      if (mhalt) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
